if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter, reads the instruction word from a local word-addressed instruction memory, and presents the fetched instruction and PC+4 to the IF/ID latch. It also handles branch/jump redirects and hazard stalls, and detects a halt instruction so the pipeline can drain and stop. The instruction memory is loaded through a simple write port used by the debug/loader logic.

## Interface
Parameters:
- IMEM_DEPTH, 256, instruction memory size in 32-bit words. Power of two.
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Word-aligned.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  fetch enable from debug control; 0 = hold PC and emit bubbles.
- stall  in  1  hazard-unit stall; holds PC.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  32  byte address of the branch target.
- jump  in  1  J/JAL/JR redirect from ID.
- jump_target  in  32  byte address of the jump target.
- imem_we  in  1  loader write strobe.
- imem_waddr  in  32  loader byte address; bits [1:0] ignored.
- imem_wdata  in  32  loader write data.
- pc_out  out  32  current PC.
- next_pc_out  out  32  pc_out + 4, to IF/ID next_pc_in.
- instr_out  out  32  fetched instruction, to IF/ID instr_in.
- halted  out  1  sticky; fetch has stopped on HALT_INSTR.

## Operation
- State: pc_reg[31:0], a 2-state FSM (RUN, HALTED), and mem[IMEM_DEPTH] of 32-bit words. halted = (state == HALTED).
- Fetch word: raw = mem[pc_reg[log2(IMEM_DEPTH)+1:2]] when pc_reg[31:2] < IMEM_DEPTH; otherwise 32'h0 (NOP).
- instr_out = raw when state==RUN and enable==1; 32'h0 otherwise.
- next_pc_out = pc_reg + 4, with 32-bit wrap-around (32'hFFFF_FFFC -> 0). pc_out = pc_reg.
- PC update priority, highest first, evaluated at each rising edge:
  - reset: pc_reg <= RESET_PC, state <= RUN.
  - branch_taken: pc_reg <= {branch_target[31:2],2'b00}; state unchanged. Ignores stall, enable and the halt check.
  - jump: pc_reg <= {jump_target[31:2],2'b00}; state unchanged.
  - stall, or enable==0, or state==HALTED: pc_reg holds.
  - raw == HALT_INSTR: pc_reg holds, state <= HALTED.
  - otherwise: pc_reg <= pc_reg + 4.
- Simultaneous branch_taken and jump: branch_taken wins. The hazard unit never asserts stall together with a redirect; if it does, the redirect still wins.
- The HALT_INSTR word itself is presented on instr_out for exactly one cycle, the transition cycle, so downstream stages see it and drain. From the next cycle instr_out = 0.
- A halt fetched while stall=1 does not transition; it transitions on the first unstalled, enabled cycle.
- HALTED is left only by reset. Redirects while halted update pc_reg, but instr_out stays 0.
- Memory write: on the rising edge with imem_we=1 and imem_waddr[31:2] < IMEM_DEPTH, mem[word] <= imem_wdata. Out-of-range writes are dropped. Writes are allowed in any state.
- Memory contents are not affected by reset.

## Timing
- Read is combinational from pc_reg: instr_out, pc_out and next_pc_out are valid in the same cycle the PC is registered. There is 0 cycles of latency from the PC to instr_out.
- Redirect latency: branch_taken/jump sampled at edge N; the target instruction is on instr_out during cycle N+1.
- Write/read same word same cycle: instr_out shows the old word; the new word is visible from the next cycle.
- Reset values: pc_out = RESET_PC, next_pc_out = RESET_PC+4, halted = 0, instr_out = mem[RESET_PC] if enable=1, else 0.
- Reset asserted mid-run or while halted: on the next edge pc_reg = RESET_PC and state = RUN; pending redirects are discarded.

## Test plan
- Load mem[0..3] = 0x20010001, 0x20020002, 0x20030003, 0xFFFFFFFF. Release reset with enable=1. Expect instr_out to show those four words on consecutive cycles, with pc_out 0, 4, 8, 0xC. Expect halted=1 from the 5th cycle, pc_out held at 0xC, and instr_out=0.
- stall=1 for 3 cycles at pc_out=4 -> pc_out and instr_out are unchanged for those 3 cycles. Sequencing resumes to 8 the cycle after stall drops.
- branch_taken=1 with branch_target=0x41 and jump=1 with jump_target=0x80 in the same cycle -> next pc_out=0x40, showing mem[16].
- HALT_INSTR at the PC while branch_taken=1 -> no halt, and the PC goes to the branch target. HALT_INSTR with stall=1 -> halted stays 0 until stall drops.
- pc_out = 0x400 with IMEM_DEPTH=256 -> instr_out=0 and the PC keeps incrementing. A loader write to 0x400 is dropped. A write to 0x10 while fetching 0x10 shows the old word, then the new word.
- Assert reset while halted -> pc_out=0 and halted=0 next cycle, with memory contents preserved.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, local instruction memory with a
// loader write port, branch/jump redirect, stall handling and sticky halt.
module if_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instr_out,
  output logic        halted
);

  localparam int          AW          = $clog2(IMEM_DEPTH);
  localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_reg;
  logic [31:0] pc_nxt;
  logic [31:0] raw;
  logic        fetch_in_range;
  logic        write_in_range;
  logic        unused_waddr_bits;

  logic [31:0] mem [IMEM_DEPTH];

  // Redirect targets are byte addresses; fetch is always word-aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // The loader ignores the byte offset within a word.
  assign unused_waddr_bits = ^imem_waddr[1:0];

  assign fetch_in_range = (pc_reg[31:2] < DEPTH_WORDS);
  assign write_in_range = (imem_waddr[31:2] < DEPTH_WORDS);

  // Loader write port; out-of-range addresses are dropped, contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we && write_in_range) begin
      mem[imem_waddr[AW+1:2]] <= imem_wdata;
    end
  end

  // Combinational read: addresses past the end of memory fetch a NOP.
  always_comb begin
    raw = 32'h0;
    if (fetch_in_range) begin
      raw = mem[pc_reg[AW+1:2]];
    end
  end

  // Next PC and halt state: redirects beat stalls/halt, halt word stops sequencing.
  always_comb begin
    pc_nxt    = pc_reg;
    state_nxt = state;
    if (branch_taken) begin
      pc_nxt = word_align(branch_target);
    end else if (jump) begin
      pc_nxt = word_align(jump_target);
    end else if (stall || !enable || (state == HALTED)) begin
      pc_nxt = pc_reg;
    end else if (raw == HALT_INSTR) begin
      state_nxt = HALTED;
    end else begin
      pc_nxt = pc_reg + 32'd4;
    end
  end

  // PC and run/halt state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
      state  <= RUN;
    end else begin
      pc_reg <= pc_nxt;
      state  <= state_nxt;
    end
  end

  assign pc_out      = pc_reg;
  assign next_pc_out = pc_reg + 32'd4;
  assign instr_out   = ((state == RUN) && enable) ? raw : 32'h0;
  assign halted      = (state == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized
// stimulus compared against a behavioural fetch model.
module tb_if_stage;

  localparam int          DEPTH     = 256;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = 32'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] instr_out;
  logic        halted;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] m_pc;
  logic        m_halted;

  if_stage #(
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (32'h0000_0000),
    .HALT_INSTR(HALT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .pc_out       (pc_out),
    .next_pc_out  (next_pc_out),
    .instr_out    (instr_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_raw();
    if (m_pc < MEM_BYTES) return model_mem[m_pc[9:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_instr();
    return (!m_halted && enable) ? m_raw() : 32'h0;
  endfunction

  // Model of one rising edge, using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] raw;
    raw = m_raw();
    if (imem_we && (imem_waddr < MEM_BYTES)) model_mem[imem_waddr[9:2]] = imem_wdata;
    if (reset) begin
      m_pc = 32'h0;
      m_halted = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target & ~32'h3;
    end else if (jump) begin
      m_pc = jump_target & ~32'h3;
    end else if (stall || !enable || m_halted) begin
      m_pc = m_pc;
    end else if (raw == HALT) begin
      m_halted = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    imem_we = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    tick();
    tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
    tests_run++; if (next_pc_out !== 32'h4) begin tests_failed++; $display("FAIL reset_next_pc: got %h want %h", next_pc_out, 32'h4); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b want 0", halted); end
    tests_run++; if (instr_out !== model_mem[0]) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", instr_out, model_mem[0]); end
    enable = 1'b0;
    #1;
    tests_run++; if (instr_out !== 32'h0) begin tests_failed++; $display("FAIL reset_instr_disabled: got %h want 0", instr_out); end
    enable = 1'b1;
  endtask

  task automatic test_sequence();
    logic [31:0] w [4];
    w[0] = 32'h2001_0001; w[1] = 32'h2002_0002; w[2] = 32'h2003_0003; w[3] = HALT;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) load_word(32'(i * 4), w[i]);
    reset = 1'b0;
    enable = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (pc_out !== 32'(i * 4)) begin tests_failed++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_out, 32'(i * 4)); end
      tests_run++; if (instr_out !== w[i]) begin tests_failed++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr_out, w[i]); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL seq_halted[%0d]: got %b want 1", k, halted); end
      tests_run++; if (pc_out !== 32'hC) begin tests_failed++; $display("FAIL seq_halt_pc[%0d]: got %h want c", k, pc_out); end
      tests_run++; if (instr_out !== 32'h0) begin tests_failed++; $display("FAIL seq_halt_instr[%0d]: got %h want 0", k, instr_out); end
      tick();
    end
  endtask

  task automatic test_stall();
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (pc_out !== 32'h4) begin tests_failed++; $display("FAIL stall_pc[%0d]: got %h want 4", k, pc_out); end
      tests_run++; if (instr_out !== 32'h2002_0002) begin tests_failed++; $display("FAIL stall_instr[%0d]: got %h want 20020002", k, instr_out); end
    end
    stall = 1'b0;
    tick();
    tests_run++; if (pc_out !== 32'h8) begin tests_failed++; $display("FAIL stall_resume_pc: got %h want 8", pc_out); end
    tests_run++; if (instr_out !== 32'h2003_0003) begin tests_failed++; $display("FAIL stall_resume_instr: got %h want 20030003", instr_out); end
  endtask

  task automatic test_redirect_priority();
    reset = 1'b1; tick(); reset = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h41;
    jump = 1'b1; jump_target = 32'h80;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    #1;
    tests_run++; if (pc_out !== 32'h40) begin tests_failed++; $display("FAIL redirect_pc: got %h want 40", pc_out); end
    tests_run++; if (instr_out !== model_mem[16]) begin tests_failed++; $display("FAIL redirect_instr: got %h want %h", instr_out, model_mem[16]); end
    jump = 1'b1; jump_target = 32'h87; stall = 1'b1;
    tick();
    jump = 1'b0; stall = 1'b0;
    tests_run++; if (pc_out !== 32'h84) begin tests_failed++; $display("FAIL jump_over_stall_pc: got %h want 84", pc_out); end
  endtask

  task automatic test_halt_corner();
    load_word(32'h20, HALT);
    branch_taken = 1'b1; branch_target = 32'h20; tick(); branch_taken = 1'b0;
    tests_run++; if (instr_out !== HALT) begin tests_failed++; $display("FAIL halt_word_shown: got %h want %h", instr_out, HALT); end
    branch_taken = 1'b1; branch_target = 32'h44; tick(); branch_taken = 1'b0;
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL halt_vs_branch_halted: got %b want 0", halted); end
    tests_run++; if (pc_out !== 32'h44) begin tests_failed++; $display("FAIL halt_vs_branch_pc: got %h want 44", pc_out); end
    jump = 1'b1; jump_target = 32'h20; tick(); jump = 1'b0;
    stall = 1'b1;
    tick(); tick();
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL halt_stalled_halted: got %b want 0", halted); end
    tests_run++; if (pc_out !== 32'h20) begin tests_failed++; $display("FAIL halt_stalled_pc: got %h want 20", pc_out); end
    stall = 1'b0;
    #1;
    tests_run++; if (instr_out !== HALT) begin tests_failed++; $display("FAIL halt_transition_instr: got %h want %h", instr_out, HALT); end
    tick();
    tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_after_stall: got %b want 1", halted); end
    tests_run++; if (instr_out !== 32'h0) begin tests_failed++; $display("FAIL halt_after_instr: got %h want 0", instr_out); end
    tests_run++; if (pc_out !== 32'h20) begin tests_failed++; $display("FAIL halt_after_pc: got %h want 20", pc_out); end
  endtask

  task automatic test_out_of_range();
    jump = 1'b1; jump_target = 32'h3F8; tick(); jump = 1'b0;
    tests_run++; if (pc_out !== 32'h3F8) begin tests_failed++; $display("FAIL halted_jump_pc: got %h want 3f8", pc_out); end
    tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halted_jump_halted: got %b want 1", halted); end
    tests_run++; if (instr_out !== 32'h0) begin tests_failed++; $display("FAIL halted_jump_instr: got %h want 0", instr_out); end
    reset = 1'b1; tick(); reset = 1'b0;
    jump = 1'b1; jump_target = 32'h3F8; tick(); jump = 1'b0;
    tests_run++; if (instr_out !== model_mem[254]) begin tests_failed++; $display("FAIL last_words_instr: got %h want %h", instr_out, model_mem[254]); end
    tick(); tick();
    tests_run++; if (pc_out !== 32'h400) begin tests_failed++; $display("FAIL oor_pc: got %h want 400", pc_out); end
    tests_run++; if (instr_out !== 32'h0) begin tests_failed++; $display("FAIL oor_instr: got %h want 0", instr_out); end
    tests_run++; if (next_pc_out !== 32'h404) begin tests_failed++; $display("FAIL oor_next_pc: got %h want 404", next_pc_out); end
    tick();
    tests_run++; if (pc_out !== 32'h404) begin tests_failed++; $display("FAIL oor_increment_pc: got %h want 404", pc_out); end
    load_word(32'h400, 32'hDEAD_BEEF);
    reset = 1'b1; tick();
    tests_run++; if (instr_out !== 32'h2001_0001) begin tests_failed++; $display("FAIL oor_write_dropped: got %h want 20010001", instr_out); end
    reset = 1'b0;
  endtask

  task automatic test_write_same_cycle();
    logic [31:0] old_w;
    logic [31:0] new_w;
    jump = 1'b1; jump_target = 32'h10; tick(); jump = 1'b0;
    stall = 1'b1;
    old_w = model_mem[4];
    new_w = old_w ^ 32'h1234_5678;
    if (new_w == HALT) new_w = 32'h0;
    imem_we = 1'b1; imem_waddr = 32'h10; imem_wdata = new_w;
    #1;
    tests_run++; if (instr_out !== old_w) begin tests_failed++; $display("FAIL write_same_cycle_old: got %h want %h", instr_out, old_w); end
    tick();
    imem_we = 1'b0;
    tests_run++; if (instr_out !== new_w) begin tests_failed++; $display("FAIL write_same_cycle_new: got %h want %h", instr_out, new_w); end
    stall = 1'b0;
  endtask

  task automatic test_reset_while_halted();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL rwh_before: got %b want 1", halted); end
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL rwh_pc: got %h want 0", pc_out); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL rwh_halted: got %b want 0", halted); end
    tests_run++; if (instr_out !== 32'h2001_0001) begin tests_failed++; $display("FAIL rwh_mem_kept: got %h want 20010001", instr_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 99) < 3);
      branch_taken  = ($urandom_range(0, 99) < 10);
      branch_target = $urandom_range(0, 32'h4FF);
      jump          = ($urandom_range(0, 99) < 10);
      jump_target   = $urandom_range(0, 32'h4FF);
      stall         = ($urandom_range(0, 99) < 20);
      enable        = ($urandom_range(0, 99) < 92);
      imem_we       = ($urandom_range(0, 99) < 15);
      imem_waddr    = $urandom_range(0, 32'h4FF);
      imem_wdata    = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
      #1;
      tests_run++; if (pc_out !== m_pc) begin tests_failed++; $display("FAIL rand_pc[%0d]: got %h want %h", n, pc_out, m_pc); end
      tests_run++; if (next_pc_out !== m_pc + 32'd4) begin tests_failed++; $display("FAIL rand_next_pc[%0d]: got %h want %h", n, next_pc_out, m_pc + 32'd4); end
      tests_run++; if (instr_out !== m_instr()) begin tests_failed++; $display("FAIL rand_instr[%0d]: got %h want %h", n, instr_out, m_instr()); end
      tests_run++; if (halted !== m_halted) begin tests_failed++; $display("FAIL rand_halted[%0d]: got %b want %b", n, halted, m_halted); end
      tick();
    end
    reset = 1'b0; branch_taken = 1'b0; jump = 1'b0; stall = 1'b0; imem_we = 1'b0; enable = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      if (d == HALT) d = 32'h0;
      load_word(32'(i * 4), d);
    end
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_priority();
    test_halt_corner();
    test_out_of_range();
    test_write_same_cycle();
    test_reset_while_halted();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
